// File: rtl/alu_pkg.sv
// Shared types for the ALU result buffer: flag bundle and buffered entry layout.
// The signed-overflow flag is only populated when ALU_RESULT_OVF_EN is defined.
package alu_pkg;

    localparam int DATA_W_DEF = 32;

    typedef struct packed {
        logic c;
        logic z;
        logic n;
        logic v;
    } alu_flags_t;

    // Result field is sized to the default ALU width; narrower builds use the low bits.
    typedef struct packed {
        logic [DATA_W_DEF-1:0] x;
        alu_flags_t            flags;
    } alu_entry_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational condition-flag derivation for one ALU result (Z, N, C and, with
// ALU_RESULT_OVF_EN defined, signed overflow V from the adder operand sign bits).
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] i_x,
    input  logic              i_cout,
    input  logic              i_aMsb,
    input  logic              i_bMsb,
    output alu_flags_t        o_flags
);

    always_comb begin
        o_flags   = '0;
        o_flags.c = i_cout;
        o_flags.z = (i_x == '0);
        o_flags.n = i_x[DATA_W-1];
`ifdef ALU_RESULT_OVF_EN
        // Overflow: operands agree in sign but the result sign differs from them.
        o_flags.v = (i_aMsb == i_bMsb) && (i_x[DATA_W-1] != i_aMsb);
`endif
    end

`ifndef ALU_RESULT_OVF_EN
    logic w_unusedMsbs;
    assign w_unusedMsbs = i_aMsb ^ i_bMsb;
`endif

endmodule

// File: rtl/alu_result_buffer.sv
// Small valid/ready FIFO between the ALU and writeback, storing result plus flags.
// Optional feature macro: ALU_RESULT_OVF_EN adds the stored V flag and the out_v port.
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_x,
    input  logic                       in_cout,
    input  logic                       in_a_msb,
    input  logic                       in_b_msb,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_x,
    output logic                       out_c,
    output logic                       out_z,
    output logic                       out_n,
`ifdef ALU_RESULT_OVF_EN
    output logic                       out_v,
`endif
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    alu_entry_t             r_mem [DEPTH];
    logic       [PTR_W-1:0] r_wrPtr;
    logic       [PTR_W-1:0] r_rdPtr;
    logic       [CNT_W-1:0] r_count;

    alu_flags_t w_pushFlags;
    alu_entry_t w_pushEntry;
    alu_entry_t w_head;
    logic       w_push;
    logic       w_pop;

    alu_flag_gen #(
        .DATA_W (DATA_W)
    ) u_flagGen (
        .i_x     (in_x),
        .i_cout  (in_cout),
        .i_aMsb  (in_a_msb),
        .i_bMsb  (in_b_msb),
        .o_flags (w_pushFlags)
    );

    assign w_pushEntry.x     = DATA_W_DEF'(in_x);
    assign w_pushEntry.flags = w_pushFlags;

    // Ready comes from the registered count only; reset forces it low while asserted.
    assign in_ready  = !rst && (r_count != CNT_W'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wrPtr] <= w_pushEntry;
                r_wrPtr        <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Outputs come straight from storage, so a push is visible one cycle later.
    assign w_head    = r_mem[r_rdPtr];
    assign out_x     = w_head.x[DATA_W-1:0];
    assign out_c     = w_head.flags.c;
    assign out_z     = w_head.flags.z;
    assign out_n     = w_head.flags.n;
    assign occupancy = r_count;

`ifdef ALU_RESULT_OVF_EN
    assign out_v = w_head.flags.v;
`else
    logic w_unusedV;
    assign w_unusedV = w_head.flags.v;
`endif

endmodule
